op_loader: RTL
==============

# op_loader

Program loader that is the encoder counterpart of the fetch/decode stage. It accepts decoded instruction fields (opcode, register numbers, immediate) over a valid/ready stream. It packs each field set into a 16-bit `OP_W` instruction word, buffers the words in a small FIFO and writes them to consecutive instruction-memory addresses. It sits between the host/test loader and the instruction memory write port, and shares that port with the core via a grant signal.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 8, instruction-memory address width
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  pulse; latches base_addr and begins a load (ignored unless IDLE)
- base_addr  in  ADDR_W  first write address
- in_valid  in  1  field set valid
- in_ready  out  1  field set accepted when in_valid && in_ready
- in_fmt  in  1  0 = register format, 1 = immediate format
- in_opcode  in  `OPCODE_W` (5)  opcode
- in_nREGA  in  `REG_N` (4)  register A
- in_nREGB  in  `REG_N` (4)  register B
- in_opdata  in  `OPDATA_W` (8)  immediate
- in_last  in  1  marks final field set of the program
- imem_we  out  1  write request; write occurs on edge where imem_we && imem_gnt
- imem_gnt  in  1  memory port granted to loader
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  `OP_W` (16)  packed word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after final word written
- word_cnt  out  ADDR_W+1  words written since last start

## Operation
- Packing:
  - fmt 0 gives {opcode, nREGA, nREGB, 3'b000}.
  - fmt 1 gives {opcode, 3'b000, opdata}; nREGA/nREGB are ignored.
  - Bit fields: opcode [15:11], regA [10:7], regB [6:3], opdata [7:0].
- FSM states:
  - IDLE
    - start → LOAD; addr ← base_addr, word_cnt ← 0, FIFO cleared.
  - LOAD
    - in_ready = !full.
    - A handshake with in_last → DRAIN.
  - DRAIN
    - in_ready = 0.
    - When the FIFO is empty and no write is pending, pulse done and go to IDLE.
- imem_we = (state ≠ IDLE) && !empty. imem_wdata = FIFO head, imem_addr = addr.
- On a write (imem_we && imem_gnt):
  - pop head;
  - addr ← addr+1, wrapping modulo 2^ADDR_W with no error;
  - word_cnt ← word_cnt+1, saturating at 2^(ADDR_W+1)−1.
- A push and a pop in the same cycle leave the count unchanged.
- Full: in_ready = 0, so no push is possible. Empty: imem_we = 0.
- start during LOAD/DRAIN is ignored.
- in_valid outside LOAD is not accepted.
- imem_gnt low holds imem_we, imem_addr and imem_wdata stable.

## Timing
- Reset values:
  - state IDLE; FIFO empty.
  - in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0.
  - busy 0, done 0, word_cnt 0.
- Reset mid-load aborts immediately; FIFO contents are discarded.
- Start: start at edge N gives busy=1 and in_ready=1 from cycle N+1.
- Latency: a field set accepted at edge N with the FIFO empty appears on imem_wdata/imem_we in cycle N+1. The write happens at edge N+1 if imem_gnt is high.
- Throughput: one word per cycle while imem_gnt is held high.
- Done: the last write occurs at edge M, done is high in cycle M+1, and busy=0 from cycle M+1.

## Structure
- OP_W, OPCODE_W, OPDATA_W and REG_N come from the shared def.h.
- Add to def.h: FMT_REG/FMT_IMM, the field bit-position constants, and the FSM state encodings.
- One sub-module: op_fifo, a parameterized synchronous FIFO of width OP_W and depth DEPTH, with a clear input. Packing logic and the FSM live in op_loader.

## Test plan
- Register format:
  - Stimulus: start with base_addr=0x10, then one set: fmt 0, opcode 5'h03, A 4'h2, B 4'h5, last=1, imem_gnt=1.
  - Expected: one write of 0x1928 at 0x10; done pulses; word_cnt=1.
- Immediate format:
  - Stimulus: fmt 1, opcode 5'h1F, opdata 8'hA5, A=4'hF (ignored).
  - Expected: imem_wdata=0xF8A5.
- Back-pressure:
  - Stimulus: imem_gnt=0 while pushing 6 sets.
  - Expected: in_ready drops after 4 accepted. Raising gnt drains writes to base..base+5 in order, one per cycle, with word_cnt=6.
- Wrap:
  - Stimulus: base_addr=0xFE, 3 words.
  - Expected: writes at 0xFE, 0xFF, 0x00; done asserted.
- Ignored inputs:
  - Stimulus: start pulsed during LOAD; in_valid high while IDLE.
  - Expected: no address reload and no write; in_ready=0 in IDLE.
- Reset mid-operation:
  - Stimulus: assert reset_n low with 3 words buffered, then release.
  - Expected: imem_we=0, busy=0, word_cnt=0. Nothing is written after release until the next start.

Source files
------------

// File: rtl/op_loader_pkg.sv
// op_loader_pkg: shared definitions for the program loader.
//   - Instruction word geometry (OP_W, OPCODE_W, OPDATA_W, REG_N)
//   - Format selectors (FMT_REG / FMT_IMM) and field bit positions
//   - Loader FSM state encoding
//   - pack_op(): builds one instruction word from decoded fields
package op_loader_pkg;

  localparam int unsigned OP_W     = 16;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned OPDATA_W = 8;
  localparam int unsigned REG_N    = 4;

  localparam logic FMT_REG = 1'b0;
  localparam logic FMT_IMM = 1'b1;

  // Field positions (LSB of each field inside the OP_W word)
  localparam int unsigned OPCODE_LSB = 11;
  localparam int unsigned REGA_LSB   = 7;
  localparam int unsigned REGB_LSB   = 3;
  localparam int unsigned OPDATA_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Register format leaves bits [2:0] zero; immediate format leaves [10:8] zero.
  function automatic logic [OP_W-1:0] pack_op(
    input logic                fmt,
    input logic [OPCODE_W-1:0] opcode,
    input logic [REG_N-1:0]    rega,
    input logic [REG_N-1:0]    regb,
    input logic [OPDATA_W-1:0] opdata
  );
    logic [OP_W-1:0] w;
    w = '0;
    w[OPCODE_LSB +: OPCODE_W] = opcode;
    if (fmt == FMT_IMM) begin
      w[OPDATA_LSB +: OPDATA_W] = opdata;
    end else begin
      w[REGA_LSB +: REG_N] = rega;
      w[REGB_LSB +: REG_N] = regb;
    end
    return w;
  endfunction

endpackage

// File: rtl/op_loader_if.sv
// op_loader_if: host-side field stream, instruction-memory write port and
// status signals of the program loader.
//   master : host / test loader plus memory arbiter (drives fields, start, gnt)
//   slave  : op_loader (drives in_ready, imem_*, busy, done, word_cnt)
interface op_loader_if
  import op_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) ();

  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic                in_valid;
  logic                in_ready;
  logic                in_fmt;
  logic [OPCODE_W-1:0] in_opcode;
  logic [REG_N-1:0]    in_nREGA;
  logic [REG_N-1:0]    in_nREGB;
  logic [OPDATA_W-1:0] in_opdata;
  logic                in_last;
  logic                imem_we;
  logic                imem_gnt;
  logic [ADDR_W-1:0]   imem_addr;
  logic [OP_W-1:0]     imem_wdata;
  logic                busy;
  logic                done;
  logic [ADDR_W:0]     word_cnt;

  modport master (
    output start, base_addr, in_valid, in_fmt, in_opcode, in_nREGA, in_nREGB,
           in_opdata, in_last, imem_gnt,
    input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, word_cnt
  );

  modport slave (
    input  start, base_addr, in_valid, in_fmt, in_opcode, in_nREGA, in_nREGB,
           in_opdata, in_last, imem_gnt,
    output in_ready, imem_we, imem_addr, imem_wdata, busy, done, word_cnt
  );

endinterface

// File: rtl/op_fifo.sv
// op_fifo: synchronous FIFO with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr_i        : empties the FIFO (pointers only)
//   push_i/wdata_i : write request (ignored when full)
//   pop_i        : read request (ignored when empty)
//   rdata_o      : current head entry (first-word fall-through)
//   full_o, empty_o, level_o : occupancy
module op_fifo
  import op_loader_pkg::*;
#(
  parameter int unsigned WIDTH = OP_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   wr_q, rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == DEPTH_L);
  assign empty_o = (wr_q == rd_q);
  assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_q <= rd_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/op_loader.sv
// op_loader: packs decoded instruction fields into OP_W words, buffers them
// in op_fifo and writes them to consecutive instruction-memory addresses.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : start/base_addr, field stream (in_*), memory write port
//                  (imem_we/gnt/addr/wdata), status (busy, done, word_cnt)
module op_loader
  import op_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  op_loader_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              push, pop, clr;
  logic              full, empty;
  logic [LVL_W-1:0]  level;
  logic [OP_W-1:0]   head;
  logic [OP_W-1:0]   packed_word;
  logic              in_ready;
  logic              imem_we;

  assign packed_word = pack_op(bus.in_fmt, bus.in_opcode, bus.in_nREGA,
                               bus.in_nREGB, bus.in_opdata);

  assign in_ready = (state_q == ST_LOAD) && !full;
  assign push     = bus.in_valid && in_ready;
  assign imem_we  = (state_q != ST_IDLE) && !empty;
  assign pop      = imem_we && bus.imem_gnt;
  assign clr      = (state_q == ST_IDLE) && bus.start;

  op_fifo #(
    .WIDTH (OP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clr),
    .push_i  (push),
    .wdata_i (packed_word),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_LOAD;
          addr_d  = bus.base_addr;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (push && bus.in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave on the edge of the final write so done/!busy show up in the
        // very next cycle rather than one cycle later.
        if (empty || (pop && level == LVL_W'(1))) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      addr_d = addr_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.imem_we    = imem_we;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = head;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = done_q;
  assign bus.word_cnt   = cnt_q;

endmodule
